// File: rtl/ddr_line_cache.sv
// rtl/ddr_line_cache.sv - direct-mapped read-only line cache in front of the DDR3 Avalon read port
module ddr_line_cache #(
    parameter int ADDR_W     = 29,
    parameter int DATA_W     = 64,
    parameter int LINE_WORDS = 8,
    parameter int NUM_LINES  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ddram_rd_in,
    input  logic [ADDR_W-1:0] ddram_addr_in,
    output logic              ddram_busy_out,
    output logic [DATA_W-1:0] ddram_readdata_out,
    output logic              ddram_valid_out,
    input  logic              invalidate_in,
    output logic [ADDR_W-1:0] ddram_addr_out,
    output logic [7:0]        ddram_burstcnt_out,
    output logic              ddram_rd_out,
    input  logic              ddram_waitrequest_in,
    input  logic              ddram_valid_in,
    input  logic [DATA_W-1:0] ddram_readdata_in
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int IDX_WS = (IDX_W > 0) ? IDX_W : 1;
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL, S_RESP} state_t;

    state_t state_q, state_d;

    // Line storage and tags carry no reset; the valid bits alone decide a hit.
    logic [DATA_W-1:0] mem_q [NUM_LINES][LINE_WORDS];
    logic [TAG_W-1:0]  tag_q [NUM_LINES];

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [OFF_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]    req_addr_q, req_addr_d;
    logic                 inv_seen_q, inv_seen_d;
    logic                 rd_out_q, rd_out_d;
    logic [ADDR_W-1:0]    addr_out_q, addr_out_d;
    logic                 valid_out_q, valid_out_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;

    function automatic logic [IDX_WS-1:0] idx_of(input logic [ADDR_W-1:0] a);
        if (IDX_W == 0) return '0;
        return IDX_WS'(a >> OFF_W);
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
        return TAG_W'(a >> (OFF_W + IDX_W));
    endfunction

    logic [IDX_WS-1:0] in_idx, req_idx;
    logic [OFF_W-1:0]  in_off, req_off;
    logic [TAG_W-1:0]  in_tag;
    logic              accept, hit, beat, last_beat;

    // Request decode: an invalidate in the same cycle forces a miss.
    always_comb begin
        in_idx    = idx_of(ddram_addr_in);
        in_off    = ddram_addr_in[OFF_W-1:0];
        in_tag    = tag_of(ddram_addr_in);
        req_idx   = idx_of(req_addr_q);
        req_off   = req_addr_q[OFF_W-1:0];
        accept    = ddram_rd_in && (state_q == S_IDLE || state_q == S_RESP);
        hit       = valid_q[in_idx] && (tag_q[in_idx] == in_tag) && !invalidate_in;
        beat      = (state_q == S_FILL) && ddram_valid_in;
        last_beat = beat && (cnt_q == OFF_W'(LINE_WORDS - 1));
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state: RESP accepts like IDLE so a new request overlaps the response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_RESP: state_d = (accept && !hit) ? S_REQ : S_IDLE;
            S_REQ:          if (!ddram_waitrequest_in) state_d = S_FILL;
            S_FILL:         if (last_beat) state_d = S_RESP;
            default:        state_d = S_IDLE;
        endcase
    end

    // FSM outputs: busy only while a line is being requested or filled.
    always_comb begin
        ddram_busy_out = (state_q == S_REQ) || (state_q == S_FILL);
    end

    // Datapath next values: valid bits, DDR command, fill counter and returned word.
    always_comb begin
        req_addr_d  = req_addr_q;
        rd_out_d    = rd_out_q;
        addr_out_d  = addr_out_q;
        valid_out_d = 1'b0;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        inv_seen_d  = inv_seen_q;
        valid_d     = valid_q;
        if (invalidate_in) valid_d = '0;
        if (invalidate_in && (state_q == S_REQ || state_q == S_FILL)) inv_seen_d = 1'b1;
        if (accept) begin
            req_addr_d = ddram_addr_in;
            if (hit) begin
                valid_out_d = 1'b1;
                rdata_d     = mem_q[in_idx][in_off];
            end else begin
                valid_d[in_idx] = 1'b0;
                addr_out_d      = {ddram_addr_in[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                rd_out_d        = 1'b1;
                inv_seen_d      = 1'b0;
            end
        end
        if (state_q == S_REQ && !ddram_waitrequest_in) rd_out_d = 1'b0;
        if (beat) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == req_off) rdata_d = ddram_readdata_in;
            if (last_beat) begin
                valid_d[req_idx] = !(inv_seen_q || invalidate_in);
                valid_out_d      = 1'b1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q     <= '0;
            cnt_q       <= '0;
            req_addr_q  <= '0;
            inv_seen_q  <= 1'b0;
            rd_out_q    <= 1'b0;
            addr_out_q  <= '0;
            valid_out_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            valid_q     <= valid_d;
            cnt_q       <= cnt_d;
            req_addr_q  <= req_addr_d;
            inv_seen_q  <= inv_seen_d;
            rd_out_q    <= rd_out_d;
            addr_out_q  <= addr_out_d;
            valid_out_q <= valid_out_d;
            rdata_q     <= rdata_d;
        end
    end

    // Line fill: each accepted beat lands at the current fill position.
    always_ff @(posedge clock) begin
        if (beat) mem_q[req_idx][cnt_q] <= ddram_readdata_in;
    end

    // Tag is written with the last beat so a partial line never matches.
    always_ff @(posedge clock) begin
        if (last_beat) tag_q[req_idx] <= tag_of(req_addr_q);
    end

    assign ddram_readdata_out = rdata_q;
    assign ddram_valid_out    = valid_out_q;
    assign ddram_addr_out     = addr_out_q;
    assign ddram_rd_out       = rd_out_q;
    assign ddram_burstcnt_out = 8'(LINE_WORDS);

endmodule

// File: tb/tb_ddr_line_cache.sv
// tb/tb_ddr_line_cache.sv - scoreboard bench for ddr_line_cache with a DDR responder model
module tb_ddr_line_cache;
    localparam int ADDR_W = 29;
    localparam int DATA_W = 64;
    localparam int LW     = 8;
    localparam int NL     = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              ddram_rd_in = 1'b0;
    logic [ADDR_W-1:0] ddram_addr_in = '0;
    logic              ddram_busy_out;
    logic [DATA_W-1:0] ddram_readdata_out;
    logic              ddram_valid_out;
    logic              invalidate_in = 1'b0;
    logic [ADDR_W-1:0] ddram_addr_out;
    logic [7:0]        ddram_burstcnt_out;
    logic              ddram_rd_out;
    logic              ddram_waitrequest_in = 1'b0;
    logic              ddram_valid_in = 1'b0;
    logic [DATA_W-1:0] ddram_readdata_in = '0;

    ddr_line_cache #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LW), .NUM_LINES(NL)) dut (
        .clock(clock), .reset(reset),
        .ddram_rd_in(ddram_rd_in), .ddram_addr_in(ddram_addr_in),
        .ddram_busy_out(ddram_busy_out), .ddram_readdata_out(ddram_readdata_out),
        .ddram_valid_out(ddram_valid_out), .invalidate_in(invalidate_in),
        .ddram_addr_out(ddram_addr_out), .ddram_burstcnt_out(ddram_burstcnt_out),
        .ddram_rd_out(ddram_rd_out), .ddram_waitrequest_in(ddram_waitrequest_in),
        .ddram_valid_in(ddram_valid_in), .ddram_readdata_in(ddram_readdata_in)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { logic [DATA_W-1:0] data; bit hit; } exp_t;
    exp_t              exp_q[$];
    logic [ADDR_W-1:0] burst_q[$];
    bit                mvalid[NL];
    logic [ADDR_W-1:0] mtag[NL];
    int n_checks = 0, n_fail = 0;
    int exp_cmds = 0, dut_cmds = 0;
    int force_wait = -1;
    int beat_i = 0;
    int last_beat_edge = 0;

    // Backing DDR contents: every word is a fixed function of its address.
    function automatic logic [DATA_W-1:0] ddr_word(input logic [ADDR_W-1:0] a);
        return ({35'h0, a} * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: actual=timeout/unexpected required=event", name);
    endtask

    task automatic model_clear();
        for (int i = 0; i < NL; i++) mvalid[i] = 1'b0;
    endtask

    // Client read: hold the request until accepted, predict hit/miss from the cache model.
    task automatic rd(input logic [ADDR_W-1:0] a);
        int w;
        int i;
        logic [ADDR_W-1:0] t;
        bit h;
        exp_t e;
        w = 0;
        ddram_rd_in   = 1'b1;
        ddram_addr_in = a;
        @(negedge clock);
        while (ddram_busy_out && w < 500) begin
            w++;
            @(negedge clock);
        end
        if (ddram_busy_out) begin
            fail("accept_timeout");
            ddram_rd_in = 1'b0;
            return;
        end
        i = int'((a / LW) % NL);
        t = a / (LW * NL);
        if (invalidate_in) model_clear();
        h = mvalid[i] && (mtag[i] == t);
        e.data = ddr_word(a);
        e.hit  = h;
        exp_q.push_back(e);
        if (!h) begin
            burst_q.push_back(a - (a % LW));
            exp_cmds++;
            mvalid[i] = 1'b1;
            mtag[i]   = t;
        end
        @(posedge clock);
        #1;
        ddram_rd_in = 1'b0;
        if (h) chk("hit_latency", ddram_valid_out, 1);
    endtask

    task automatic inval();
        invalidate_in = 1'b1;
        @(posedge clock);
        #1;
        invalidate_in = 1'b0;
        model_clear();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((ddram_busy_out || ddram_rd_out || exp_q.size() != 0) && w < 1000) begin
            @(posedge clock);
            #1;
            w++;
        end
        if (w >= 1000) fail("idle_timeout");
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", ddram_busy_out, 0);
        chk("rst_valid", ddram_valid_out, 0);
        chk("rst_rd_out", ddram_rd_out, 0);
        chk("rst_addr_out", ddram_addr_out, 0);
        chk("rst_readdata", ddram_readdata_out, 0);
        chk("rst_burstcnt", ddram_burstcnt_out, LW);
    endtask

    // Monitor: every valid strobe pops one expected response.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && ddram_valid_out) begin
                if (exp_q.size() == 0) fail("spurious_valid");
                else begin
                    e = exp_q.pop_front();
                    chk("read_data", ddram_readdata_out, e.data);
                    if (!e.hit) chk("miss_latency", cyc, last_beat_edge);
                end
            end
        end
    end

    // DDR responder: random waitrequest, gapped beats, stray beats outside bursts.
    initial begin : ddr_model
        int pending, wait_left, rd_cycles;
        bit seen;
        logic [ADDR_W-1:0] base, cmd_addr;
        pending = 0; wait_left = 0; rd_cycles = 0; seen = 1'b0; base = '0; cmd_addr = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                pending = 0; seen = 1'b0; beat_i = 0;
                ddram_waitrequest_in = 1'b0;
                ddram_valid_in = 1'b0;
                continue;
            end
            if (pending > 0 && $urandom_range(0, 3) != 0) begin
                ddram_valid_in    = 1'b1;
                ddram_readdata_in = ddr_word(base + ADDR_W'(beat_i));
                beat_i++;
                pending--;
                if (pending == 0) last_beat_edge = cyc + 1;
            end else if (pending == 0 && $urandom_range(0, 7) == 0) begin
                ddram_valid_in    = 1'b1;
                ddram_readdata_in = {$urandom, $urandom};
            end else begin
                ddram_valid_in = 1'b0;
            end
            if (ddram_rd_out) begin
                if (!seen) begin
                    seen = 1'b1;
                    cmd_addr = ddram_addr_out;
                    rd_cycles = 0;
                    wait_left = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 2));
                end else begin
                    chk("cmd_addr_stable", ddram_addr_out, cmd_addr);
                end
                rd_cycles++;
                chk("burstcnt", ddram_burstcnt_out, LW);
                if (wait_left > 0) begin
                    ddram_waitrequest_in = 1'b1;
                    wait_left--;
                end else begin
                    ddram_waitrequest_in = 1'b0;
                    dut_cmds++;
                    if (burst_q.size() == 0) fail("unexpected_cmd");
                    else chk("cmd_addr", ddram_addr_out, burst_q.pop_front());
                    if (force_wait >= 0) chk("cmd_hold_cycles", rd_cycles, force_wait + 1);
                    base = ddram_addr_out;
                    beat_i = 0;
                    pending = LW;
                    seen = 1'b0;
                end
            end else begin
                if (seen) fail("cmd_dropped");
                ddram_waitrequest_in = 1'b0;
                seen = 1'b0;
            end
        end
    end

    initial begin : stimulus
        int w;
        model_clear();
        repeat (3) @(posedge clock);
        #1;
        chk_reset_outputs();
        reset = 1'b0;
        idle(1);

        rd(29'h100);
        rd(29'h105);
        rd(29'h107);
        rd(29'h100);
        wait_idle();

        rd(29'h108);
        rd(29'h100);
        rd(29'h120);
        rd(29'h100);
        wait_idle();

        force_wait = 5;
        rd(29'h400);
        wait_idle();
        force_wait = -1;

        rd(29'h203);
        w = 0;
        while (beat_i < 3 && w < 200) begin @(negedge clock); #2; w++; end
        if (w >= 200) fail("midfill_timeout");
        inval();
        wait_idle();
        rd(29'h203);
        wait_idle();

        rd(29'h300);
        w = 0;
        while (!(ddram_valid_in && beat_i == 5) && w < 200) begin @(negedge clock); #2; w++; end
        if (w >= 200) fail("beat4_timeout");
        reset = 1'b1;
        exp_q.delete();
        burst_q.delete();
        model_clear();
        @(posedge clock);
        #1;
        chk_reset_outputs();
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(1);
        rd(29'h300);
        wait_idle();

        rd(29'h100);
        wait_idle();
        invalidate_in = 1'b1;
        rd(29'h100);
        invalidate_in = 1'b0;
        wait_idle();

        for (int n = 0; n < 300; n++) begin
            int r;
            r = int'($urandom_range(0, 39));
            if (r == 0) inval();
            else if (r < 4) idle(int'($urandom_range(0, 3)));
            rd(ADDR_W'($urandom_range(0, 127)) | (ADDR_W'($urandom_range(0, 1)) << 20));
        end
        wait_idle();

        chk("cmd_count", dut_cmds, exp_cmds);
        chk("pending_bursts", burst_q.size(), 0);
        chk("pending_responses", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
